input_debounce3: RTL and testbench

//  Conditions the three raw board inputs (slide switches / push buttons) that feed the
//  a/b/c inputs of the combinational logic stage downstream.
//  Per input: 2-flop synchronizer, then counter-based debounce.

---
 rtl/input_debounce3.sv | 61 ++++++
 tb/tb_input_debounce3.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debounce3.sv
// Three-input pin conditioner: 2-flop synchronizer plus counter debounce per bit,
// with registered clean levels and one-cycle rise/fall pulses.
module input_debounce3 #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_a,
    input  logic       raw_b,
    input  logic       raw_c,
    output logic       clean_a,
    output logic       clean_b,
    output logic       clean_c,
    output logic [2:0] rise,
    output logic [2:0] fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       clean;
    logic [CNT_W-1:0] cnt [3];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            clean <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= {raw_c, raw_b, raw_a};
            s2   <= s1;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    // mismatch persisted long enough: follow it and flag the edge
                    clean[i] <= s2[i];
                    cnt[i]   <= '0;
                    rise[i]  <= s2[i];
                    fall[i]  <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign clean_a = clean[0];
    assign clean_b = clean[1];
    assign clean_c = clean[2];

endmodule

// File: tb/tb_input_debounce3.sv
// Bench for input_debounce3: directed scenarios plus random stimulus, checked
// against a history-window model for DEBOUNCE_CYCLES=4 and DEBOUNCE_CYCLES=1.
module tb_input_debounce3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw_a = 1'b0;
    logic       raw_b = 1'b0;
    logic       raw_c = 1'b0;
    logic       clean_a, clean_b, clean_c;
    logic [2:0] rise, fall;
    logic       clean1_a, clean1_b, clean1_c;
    logic [2:0] rise1, fall1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    input_debounce3 #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .raw_a(raw_a), .raw_b(raw_b), .raw_c(raw_c),
        .clean_a(clean_a), .clean_b(clean_b), .clean_c(clean_c),
        .rise(rise), .fall(fall)
    );

    input_debounce3 #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .raw_a(raw_a), .raw_b(raw_b), .raw_c(raw_c),
        .clean_a(clean1_a), .clean_b(clean1_b), .clean_c(clean1_c),
        .rise(rise1), .fall(fall1)
    );

    // Model: clean follows s2 once s2 has shown the same differing value on
    // the last D edges, all of them after the latest reset or clean change.
    int       dc [2] = '{4, 1};
    int       ed = 0;
    bit [2:0] m_s1 [2];
    bit [2:0] m_s2 [2];
    bit [2:0] m_clean [2];
    bit [2:0] m_rise [2];
    bit [2:0] m_fall [2];
    bit       hist [2][3][8192];
    int       blk [2][3];

    task automatic model_edge(input bit r, input bit [2:0] raw);
        for (int i = 0; i < 2; i++) begin
            m_rise[i] = '0;
            m_fall[i] = '0;
            for (int b = 0; b < 3; b++) begin
                if (r) begin
                    m_clean[i][b] = 1'b0;
                    blk[i][b] = ed;
                end else begin
                    bit d;
                    bit ok;
                    d = m_s2[i][b];
                    hist[i][b][ed] = d;
                    ok = (ed - blk[i][b] >= dc[i]) && (d != m_clean[i][b]);
                    for (int j = 0; j < dc[i]; j++) begin
                        if (ok && hist[i][b][ed-j] != d) ok = 1'b0;
                    end
                    if (ok) begin
                        m_clean[i][b] = d;
                        m_rise[i][b] = d;
                        m_fall[i][b] = ~d;
                        blk[i][b] = ed;
                    end
                end
            end
            m_s2[i] = r ? 3'b000 : m_s1[i];
            m_s1[i] = r ? 3'b000 : raw;
        end
        ed++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, {raw_c, raw_b, raw_a});
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {raw_c, raw_b, raw_a} = 3'b111;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({clean_c, clean_b, clean_a, rise, fall} !== 9'd0) begin
                errors++;
                $display("FAIL reset_hold c=%0d got clean=%b rise=%b fall=%b need all 0",
                         c, {clean_c, clean_b, clean_a}, rise, fall);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            checks++;
            if ({clean_c, clean_b, clean_a, rise, fall} !==
                {(c >= 5) ? 3'b111 : 3'b000, (c == 5) ? 3'b111 : 3'b000, 3'b000}) begin
                errors++;
                $display("FAIL reset_release c=%0d got clean=%b rise=%b fall=%b",
                         c, {clean_c, clean_b, clean_a}, rise, fall);
            end
        end
    endtask

    task automatic test_fall_all();
        {raw_c, raw_b, raw_a} = 3'b000;
        for (int c = 0; c < 7; c++) begin
            step();
            checks++;
            if ({clean_c, clean_b, clean_a, fall, rise} !==
                {(c >= 5) ? 3'b000 : 3'b111, (c == 5) ? 3'b111 : 3'b000, 3'b000}) begin
                errors++;
                $display("FAIL fall_all c=%0d got clean=%b rise=%b fall=%b",
                         c, {clean_c, clean_b, clean_a}, rise, fall);
            end
        end
    endtask

    task automatic test_glitch();
        raw_b = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 2) raw_b = 1'b0;
            checks++;
            if (clean_b !== 1'b0 || (rise | fall) !== 3'b000 ||
                {clean_c, clean_b, clean_a, rise, fall} !==
                {m_clean[0], m_rise[0], m_fall[0]}) begin
                errors++;
                $display("FAIL glitch_b c=%0d got clean_b=%b rise=%b fall=%b need 0/000/000",
                         c, clean_b, rise, fall);
            end
        end
    endtask

    task automatic test_bounce();
        bit [4:0] seq = 5'b10101;
        int       seen = -1;
        for (int c = 0; c < 5; c++) begin
            raw_c = seq[4-c];
            step();
        end
        for (int c = 1; c < 9; c++) begin
            step();
            if (rise[2] === 1'b1 && seen < 0) seen = c;
            checks++;
            if (fall !== 3'b000 ||
                {clean_c, clean_b, clean_a, rise, fall} !==
                {m_clean[0], m_rise[0], m_fall[0]}) begin
                errors++;
                $display("FAIL bounce_c c=%0d got clean=%b rise=%b fall=%b model clean=%b",
                         c, {clean_c, clean_b, clean_a}, rise, fall, m_clean[0]);
            end
        end
        checks++;
        if (seen !== 5 || clean_c !== 1'b1) begin
            errors++;
            $display("FAIL bounce_latency got rise at +%0d clean_c=%b need +5 and 1",
                     seen, clean_c);
        end
    endtask

    task automatic test_reset_mid();
        raw_a = 1'b1;
        for (int c = 0; c < 4; c++) step();
        rst = 1'b1;
        step();
        checks++;
        if ({clean_c, clean_b, clean_a, rise, fall} !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid got clean=%b rise=%b fall=%b need all 0",
                     {clean_c, clean_b, clean_a}, rise, fall);
        end
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            checks++;
            if (clean_a !== (c >= 5) || rise[0] !== (c == 5) ||
                {clean_c, clean_b, clean_a, rise, fall} !==
                {m_clean[0], m_rise[0], m_fall[0]}) begin
                errors++;
                $display("FAIL reset_mid_release c=%0d got clean_a=%b rise=%b need %b/%b",
                         c, clean_a, rise, c >= 5, c == 5);
            end
        end
    endtask

    task automatic test_d1();
        int highs = 0;
        {raw_c, raw_b, raw_a} = 3'b000;
        for (int c = 0; c < 4; c++) step();
        raw_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (clean1_a !== (c >= 2) || rise1[0] !== (c == 2)) begin
                errors++;
                $display("FAIL d1_latency c=%0d got clean_a=%b rise=%b need %b/%b",
                         c, clean1_a, rise1, c >= 2, c == 2);
            end
        end
        raw_a = 1'b0;
        for (int c = 0; c < 4; c++) step();
        raw_a = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            raw_a = 1'b0;
            if (clean1_a === 1'b1) highs++;
            checks++;
            if ({clean1_c, clean1_b, clean1_a, rise1, fall1} !==
                {m_clean[1], m_rise[1], m_fall[1]}) begin
                errors++;
                $display("FAIL d1_pulse c=%0d got clean=%b rise=%b fall=%b model %b",
                         c, {clean1_c, clean1_b, clean1_a}, rise1, fall1, m_clean[1]);
            end
        end
        checks++;
        if (highs !== 1) begin
            errors++;
            $display("FAIL d1_pulse_width got %0d high cycles need 1", highs);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case (b)
                        0: raw_a = ~raw_a;
                        1: raw_b = ~raw_b;
                        default: raw_c = ~raw_c;
                    endcase
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if ({clean_c, clean_b, clean_a, rise, fall} !==
                    {m_clean[0], m_rise[0], m_fall[0]} ||
                {clean1_c, clean1_b, clean1_a, rise1, fall1} !==
                    {m_clean[1], m_rise[1], m_fall[1]} ||
                (rise & fall) !== 3'b000 || (rise1 & fall1) !== 3'b000) begin
                errors++;
                $display("FAIL random c=%0d got %b/%b/%b d1 %b/%b/%b need %b/%b/%b d1 %b/%b/%b",
                         c, {clean_c, clean_b, clean_a}, rise, fall,
                         {clean1_c, clean1_b, clean1_a}, rise1, fall1,
                         m_clean[0], m_rise[0], m_fall[0],
                         m_clean[1], m_rise[1], m_fall[1]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fall_all();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_d1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
